debounce_scheduler: RTL and testbench

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

---
 rtl/debounce_scheduler.sv | 127 ++++++++++++
 tb/tb_debounce_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer: all channels share one down-counter.
// A round-robin arbiter grants the counter to one channel at a time.
module debounce_scheduler #(
  parameter int CH = 4,
  parameter int N  = 21,
  localparam int OW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] db_tick,
  output logic          busy,
  output logic [OW-1:0] owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01
  } state_t;

  localparam logic [OW:0] CH_W = (OW+1)'(CH);

  state_t        r_state, w_state_next;
  logic [CH-1:0] r_sync1, r_sync2;
  logic [CH-1:0] r_db_level, w_level_next;
  logic [CH-1:0] r_db_tick, w_tick_next;
  logic [N-1:0]  r_timer, w_timer_next;
  logic [OW-1:0] r_owner, w_owner_next;
  logic [OW-1:0] r_ptr, w_ptr_next;

  logic [CH-1:0]   w_req;
  logic [2*CH-1:0] w_req2;
  logic [CH-1:0]   w_rot;
  logic            w_grant_valid;
  logic [OW-1:0]   w_off;
  logic [OW-1:0]   w_grant_idx;
  logic [OW-1:0]   w_grant_inc;
  logic [OW:0]     w_sum;
  logic [OW:0]     w_inc;
  logic            w_last_count;

  assign w_req  = r_sync2 ^ r_db_level;
  // Rotate requests so that bit 0 is the channel the search starts from.
  assign w_req2 = {w_req, w_req};
  assign w_rot  = CH'(w_req2 >> r_ptr);

  always_comb begin
    w_grant_valid = 1'b0;
    w_off         = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_grant_valid = 1'b1;
        w_off         = OW'(k);
      end
    end
  end

  assign w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_grant_idx = (w_sum >= CH_W) ? OW'(w_sum - CH_W) : OW'(w_sum);
  assign w_inc       = {1'b0, w_grant_idx} + (OW+1)'(1);
  assign w_grant_inc = (w_inc >= CH_W) ? OW'(w_inc - CH_W) : OW'(w_inc);
  // The edge that takes the timer from 1 to 0 is the completing edge.
  assign w_last_count = (r_timer == N'(1)) || (r_timer == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_db_level <= '0;
      r_db_tick  <= '0;
      r_timer    <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_sync1    <= sw;
      r_sync2    <= r_sync1;
      r_db_level <= w_level_next;
      r_db_tick  <= w_tick_next;
      r_timer    <= w_timer_next;
      r_owner    <= w_owner_next;
      r_ptr      <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_level_next = r_db_level;
    w_tick_next  = '0;
    w_timer_next = r_timer;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_grant_valid) begin
          w_state_next = S_COUNT;
          w_timer_next = '1;
          w_owner_next = w_grant_idx;
          w_ptr_next   = w_grant_inc;
        end
      end
      S_COUNT: begin
        if (r_sync2[r_owner] == r_db_level[r_owner]) begin
          w_state_next = S_IDLE;
        end else if (w_last_count) begin
          w_state_next          = S_IDLE;
          w_timer_next          = '0;
          w_level_next[r_owner] = ~r_db_level[r_owner];
          w_tick_next[r_owner]  = ~r_db_level[r_owner];
        end else begin
          w_timer_next = r_timer - N'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign db_level = r_db_level;
  assign db_tick  = r_db_tick;
  assign busy     = (r_state == S_COUNT);
  assign owner    = r_owner;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (CH=4, N=4): expected level changes
// are queued with their due cycle when stimulus is applied and matched as they occur.
module tb_debounce_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic [3:0] db_level;
  logic [3:0] db_tick;
  logic       busy;
  logic [1:0] owner;

  typedef struct {
    int   ch;
    logic lvl;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  debounce_scheduler #(.CH(4), .N(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick),
    .busy     (busy),
    .owner    (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic lvl, input int due);
    exp_t e;
    e.ch  = ch;
    e.lvl = lvl;
    e.cyc = due;
    q.push_back(e);
    $display("expect ch%0d -> %0b at cycle %0d", ch, lvl, due);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    sw    = 4'b0000;
    reset = 1'b0;
    #1;
    chk({tag, "_level"}, 32'(db_level), 32'd0);
    chk({tag, "_tick"},  32'(db_tick),  32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
    chk({tag, "_owner"}, 32'(owner),    32'd0);
    chk({tag, "_queue"}, 32'(q.size()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every level change must match the next queued expectation,
  // and ticks must appear exactly on rising changes.
  initial begin
    logic [3:0] prev_level;
    exp_t       e;
    prev_level = 4'b0000;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_level = 4'b0000;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (db_level[i] !== prev_level[i]) begin
            chk("pending_expectation", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
              e = q.pop_front();
              $display("change ch%0d -> %0b at cycle %0d (expected ch%0d -> %0b at %0d)",
                       i, db_level[i], cyc, e.ch, e.lvl, e.cyc);
              chk("change_ch",    32'(i),           32'(e.ch));
              chk("change_level", 32'(db_level[i]), 32'(e.lvl));
              chk("change_cycle", 32'(cyc),         32'(e.cyc));
            end
          end
        end
        chk("tick_vs_rise", 32'(db_tick), 32'(db_level & ~prev_level));
        prev_level = db_level;
      end
    end
  end

  initial begin
    int c0;
    int bc;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    sw          = 4'b0000;

    // Reset state and first single-channel debounce
    repeat (2) @(negedge clk);
    do_reset("rst0");
    @(negedge clk);
    sw = 4'b0001;
    c0 = cyc;
    push(0, 1'b1, c0 + 18);
    bc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("ch0_busy_cycles", 32'(bc), 32'd15);
    wait_drain("ch0_drain", 5);
    chk("ch0_level", 32'(db_level), 32'b0001);

    // Bouncing ch1: grant/abort only, no level change
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      sw[1] = ~sw[1];
      $display("bounce step %0d sw=%b", k, sw);
      repeat (5) begin
        @(negedge clk);
        if (busy) bc++;
      end
    end
    repeat (20) @(negedge clk);
    chk("bounce_granted", 32'(bc != 0), 32'd1);
    chk("bounce_level", 32'(db_level), 32'b0001);
    chk("bounce_owner", 32'(owner), 32'd1);
    chk("bounce_busy", 32'(busy), 32'd0);

    // All four channels at once: round-robin 0,1,2,3, 16 cycles apart
    do_reset("rst1");
    @(negedge clk);
    sw = 4'b1111;
    c0 = cyc;
    push(0, 1'b1, c0 + 18);
    push(1, 1'b1, c0 + 34);
    push(2, 1'b1, c0 + 50);
    push(3, 1'b1, c0 + 66);
    wait_drain("all_drain", 90);
    chk("all_level", 32'(db_level), 32'b1111);

    // After ch2 grant, ch0 and ch3 together: ch3 wins first
    do_reset("rst2");
    @(negedge clk);
    sw = 4'b0100;
    c0 = cyc;
    push(2, 1'b1, c0 + 18);
    wait_drain("ch2_drain", 30);
    @(negedge clk);
    sw = 4'b1101;
    c0 = cyc;
    push(3, 1'b1, c0 + 18);
    push(0, 1'b1, c0 + 34);
    wait_drain("rr_drain", 50);
    chk("rr_level", 32'(db_level), 32'b1101);

    // Falling debounce of ch2: level drops, no tick
    @(negedge clk);
    sw = 4'b1001;
    c0 = cyc;
    push(2, 1'b0, c0 + 18);
    wait_drain("fall_drain", 30);
    chk("fall_level", 32'(db_level), 32'b1001);

    // Reset in the middle of ch1's count discards it; both redone after release
    do_reset("rst3");
    @(negedge clk);
    sw = 4'b0011;
    c0 = cyc;
    push(0, 1'b1, c0 + 18);
    repeat (25) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_owner", 32'(owner), 32'd1);
    chk("mid_level", 32'(db_level), 32'b0001);
    chk("mid_queue", 32'(q.size()), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_level", 32'(db_level), 32'd0);
    chk("async_tick",  32'(db_tick),  32'd0);
    chk("async_busy",  32'(busy),     32'd0);
    chk("async_owner", 32'(owner),    32'd0);
    @(negedge clk);
    reset = 1'b1;
    c0 = cyc;
    push(0, 1'b1, c0 + 18);
    push(1, 1'b1, c0 + 34);
    wait_drain("redo_drain", 50);
    chk("redo_level", 32'(db_level), 32'b0011);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
